// File: rtl/axi2ahb_pkg.sv
// Shared encodings for the AXI-to-AHB bridge: burst types, response codes and
// the address-channel front-end state machine.
package axi2ahb_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_ACT  = 2'b01,
    WR_ACT  = 2'b10,
    WR_RESP = 2'b11
  } state_e;

  // The AHB side has no reserved burst, so it is carried as INCR and flagged.
  function automatic logic [1:0] map_burst(input logic [1:0] burst);
    return (burst == BURST_RSVD) ? BURST_INCR : burst;
  endfunction

endpackage

// File: rtl/axi2ahb_rr_arb.sv
// Two-requester round-robin arbiter; a tie goes to the side that did not win
// the previous grant.
module axi2ahb_rr_arb (
  input  logic ACLK,
  input  logic ARESET,
  input  logic req_w,
  input  logic req_r,
  input  logic en,
  output logic grant_w,
  output logic grant_r
);

  // 1 when the most recent grant went to the write side; resets to READ.
  logic last_w_r;

  assign grant_w = req_w & (~req_r | ~last_w_r);
  assign grant_r = req_r & (~req_w |  last_w_r);

  // Remember the winner of each granted arbitration round.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_w_r <= 1'b0;
    end else if (en && (grant_w || grant_r)) begin
      last_w_r <= grant_w;
    end
  end

endmodule

// File: rtl/axi2ahb_cmd.sv
// AXI address-channel front end: arbitrates AW/AR, holds one command for the
// AHB control stage, and returns the B response after a write completes.
module axi2ahb_cmd
  import axi2ahb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic                      cmd_read_o,
  output logic                      cmd_write_o,
  output logic [AXI_ADDR_WIDTH-1:0] cmd_start_addr_o,
  output logic [7:0]                cmd_transfer_len_o,
  output logic [1:0]                cmd_burst_type_o,
  output logic                      ctrl_cmd_valid_o,
  input  logic                      ctrl_cmd_ready_i
);

  state_e state_r;
  state_e state_nx_s;
  logic   idle_s;
  logic   grant_w_s;
  logic   grant_r_s;
  logic   acc_w_s;
  logic   acc_r_s;
  logic   err_r;

  // Readies must already be low during reset, so reset gates the accept window.
  assign idle_s  = (state_r == IDLE) & ~ARESET;
  assign acc_w_s = idle_s & grant_w_s;
  assign acc_r_s = idle_s & grant_r_s;
  assign AWREADY = acc_w_s;
  assign ARREADY = acc_r_s;

  axi2ahb_rr_arb u_arb (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .req_w   (AWVALID),
    .req_r   (ARVALID),
    .en      (idle_s),
    .grant_w (grant_w_s),
    .grant_r (grant_r_s)
  );

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (acc_w_s) begin
          state_nx_s = WR_ACT;
        end else if (acc_r_s) begin
          state_nx_s = RD_ACT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD_ACT: begin
        if (ctrl_cmd_ready_i) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RD_ACT;
        end
      end
      WR_ACT: begin
        if (ctrl_cmd_ready_i) begin
          state_nx_s = WR_RESP;
        end else begin
          state_nx_s = WR_ACT;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WR_RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Registered outputs follow the next state; command fields latch on accept.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_cmd_valid_o   <= 1'b0;
      cmd_read_o         <= 1'b0;
      cmd_write_o        <= 1'b0;
      BVALID             <= 1'b0;
      BRESP              <= RESP_OKAY;
      cmd_start_addr_o   <= {AXI_ADDR_WIDTH{1'b0}};
      cmd_transfer_len_o <= 8'd0;
      cmd_burst_type_o   <= BURST_FIXED;
      err_r              <= 1'b0;
    end else begin
      ctrl_cmd_valid_o <= (state_nx_s == RD_ACT) || (state_nx_s == WR_ACT);
      cmd_read_o       <= (state_nx_s == RD_ACT);
      cmd_write_o      <= (state_nx_s == WR_ACT);
      BVALID           <= (state_nx_s == WR_RESP);
      BRESP            <= ((state_nx_s == WR_RESP) && err_r) ? RESP_SLVERR : RESP_OKAY;
      if (acc_w_s) begin
        cmd_start_addr_o   <= {AWADDR[AXI_ADDR_WIDTH-1:2], 2'b00};
        cmd_transfer_len_o <= AWLEN;
        cmd_burst_type_o   <= map_burst(AWBURST);
        err_r              <= (AWBURST == BURST_RSVD);
      end else if (acc_r_s) begin
        cmd_start_addr_o   <= {ARADDR[AXI_ADDR_WIDTH-1:2], 2'b00};
        cmd_transfer_len_o <= ARLEN;
        cmd_burst_type_o   <= map_burst(ARBURST);
        err_r              <= (ARBURST == BURST_RSVD);
      end
    end
  end

endmodule

// File: tb/tb_axi2ahb_cmd.sv
// Self-checking bench for axi2ahb_cmd: directed scenarios plus randomized
// commands checked against a transaction-level model of grant order and fields.
module tb_axi2ahb_cmd;

  logic       ACLK;
  logic       ARESET;
  logic [7:0] AWADDR;
  logic [7:0] AWLEN;
  logic [1:0] AWBURST;
  logic       AWVALID;
  logic       AWREADY;
  logic [7:0] ARADDR;
  logic [7:0] ARLEN;
  logic [1:0] ARBURST;
  logic       ARVALID;
  logic       ARREADY;
  logic [1:0] BRESP;
  logic       BVALID;
  logic       BREADY;
  logic       cmd_read_o;
  logic       cmd_write_o;
  logic [7:0] cmd_start_addr_o;
  logic [7:0] cmd_transfer_len_o;
  logic [1:0] cmd_burst_type_o;
  logic       ctrl_cmd_valid_o;
  logic       ctrl_cmd_ready_i;

  int total;
  int bad;
  bit model_last_w;  // model: 1 if the previous grant went to the write side
  logic [7:0] last_addr;
  logic [7:0] last_len;
  logic [1:0] last_burst;

  axi2ahb_cmd #(.AXI_ADDR_WIDTH(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .cmd_read_o(cmd_read_o), .cmd_write_o(cmd_write_o),
    .cmd_start_addr_o(cmd_start_addr_o), .cmd_transfer_len_o(cmd_transfer_len_o),
    .cmd_burst_type_o(cmd_burst_type_o),
    .ctrl_cmd_valid_o(ctrl_cmd_valid_o), .ctrl_cmd_ready_i(ctrl_cmd_ready_i)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  function automatic logic [1:0] exp_burst(input logic [1:0] b);
    return (b == 2'b11) ? 2'b01 : b;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [1:0] b);
    return (b == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  task automatic test_reset();
    ARESET = 1'b1; AWVALID = 1'b1; ARVALID = 1'b1;
    tick(); tick(); #1;
    total++;
    if ({AWREADY, ARREADY} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b want 00", {AWREADY, ARREADY});
    end
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, BVALID, BRESP} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000",
                      {ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, BVALID, BRESP});
    end
    total++;
    if ({cmd_start_addr_o, cmd_transfer_len_o, cmd_burst_type_o} !== 18'd0) begin
      bad++; $display("FAIL reset_cmd: got %h/%h/%b want 0", cmd_start_addr_o,
                      cmd_transfer_len_o, cmd_burst_type_o);
    end
    AWVALID = 1'b0; ARVALID = 1'b0; ARESET = 1'b0;
    model_last_w = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    ARADDR = 8'h13; ARLEN = 8'd3; ARBURST = 2'b01; ARVALID = 1'b1; #1;
    total++;
    if ({ARREADY, AWREADY} !== 2'b10) begin
      bad++; $display("FAIL rd_handshake: got ar/aw=%b want 10", {ARREADY, AWREADY});
    end
    tick(); ARVALID = 1'b0; #1;
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, cmd_start_addr_o, cmd_transfer_len_o,
         cmd_burst_type_o} !== {3'b110, 8'h10, 8'd3, 2'b01}) begin
      bad++; $display("FAIL rd_cmd: got v/r/w=%b addr=%h len=%0d burst=%b want 110 10 3 01",
                      {ctrl_cmd_valid_o, cmd_read_o, cmd_write_o}, cmd_start_addr_o,
                      cmd_transfer_len_o, cmd_burst_type_o);
    end
    repeat (3) tick();
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, cmd_start_addr_o, cmd_transfer_len_o} !==
        {2'b11, 8'h10, 8'd3}) begin
      bad++; $display("FAIL rd_hold: got v/r=%b addr=%h len=%0d",
                      {ctrl_cmd_valid_o, cmd_read_o}, cmd_start_addr_o, cmd_transfer_len_o);
    end
    ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0; #1;
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, BVALID} !== 3'b000) begin
      bad++; $display("FAIL rd_done: got v/r/bvalid=%b want 000",
                      {ctrl_cmd_valid_o, cmd_read_o, BVALID});
    end
    model_last_w = 1'b0;
  endtask

  task automatic test_single_write();
    AWADDR = 8'h20; AWLEN = 8'd7; AWBURST = 2'b10; AWVALID = 1'b1; BREADY = 1'b0; #1;
    total++;
    if ({AWREADY, ARREADY} !== 2'b10) begin
      bad++; $display("FAIL wr_handshake: got aw/ar=%b want 10", {AWREADY, ARREADY});
    end
    tick(); AWVALID = 1'b0;
    repeat (4) tick();
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, cmd_start_addr_o, cmd_transfer_len_o,
         cmd_burst_type_o} !== {3'b101, 8'h20, 8'd7, 2'b10}) begin
      bad++; $display("FAIL wr_hold: got v/r/w=%b addr=%h len=%0d burst=%b want 101 20 7 10",
                      {ctrl_cmd_valid_o, cmd_read_o, cmd_write_o}, cmd_start_addr_o,
                      cmd_transfer_len_o, cmd_burst_type_o);
    end
    ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0;
    total++;
    if ({BVALID, BRESP, ctrl_cmd_valid_o, cmd_write_o} !== 5'b10000) begin
      bad++; $display("FAIL wr_bresp: got bvalid/bresp/v/w=%b want 10000",
                      {BVALID, BRESP, ctrl_cmd_valid_o, cmd_write_o});
    end
    ARADDR = 8'($urandom); ARVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({BVALID, ARREADY, AWREADY} !== 3'b100) begin
        bad++; $display("FAIL wr_bstall: cycle %0d got bvalid/ar/aw=%b want 100", i,
                        {BVALID, ARREADY, AWREADY});
      end
      tick();
    end
    ARVALID = 1'b0; BREADY = 1'b1;
    tick();
    total++;
    if (BVALID !== 1'b0) begin
      bad++; $display("FAIL wr_bdone: got bvalid=%b want 0", BVALID);
    end
    model_last_w = 1'b1;
  endtask

  task automatic test_contention();
    int n;
    int cyc;
    bit exp_w;
    ARESET = 1'b1; AWVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1;
    AWADDR = 8'($urandom); ARADDR = 8'($urandom);
    tick(); ARESET = 1'b0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 80) begin
      #1;
      total++;
      if (AWREADY && ARREADY) begin
        bad++; $display("FAIL cont_both_ready: got aw=1 ar=1 want at most one");
      end
      ctrl_cmd_ready_i = ctrl_cmd_valid_o;
      if (AWREADY || ARREADY) begin
        exp_w = (n % 2 == 0);
        total++;
        if (AWREADY !== exp_w) begin
          bad++; $display("FAIL cont_grant: grant %0d got aw=%b want aw=%b", n, AWREADY, exp_w);
        end
        n++;
      end
      tick();
      cyc++;
    end
    AWVALID = 1'b0; ARVALID = 1'b0;
    cyc = 0;
    while ((ctrl_cmd_valid_o || BVALID) && cyc < 20) begin
      ctrl_cmd_ready_i = ctrl_cmd_valid_o;
      tick();
      cyc++;
    end
    ctrl_cmd_ready_i = 1'b0;
    total++;
    if (n !== 4 || ctrl_cmd_valid_o !== 1'b0) begin
      bad++; $display("FAIL cont_timeout: got grants=%0d valid=%b want 4 0", n, ctrl_cmd_valid_o);
    end
    model_last_w = 1'b0;
  endtask

  task automatic test_reserved();
    logic [7:0] a;
    logic [7:0] l;
    a = 8'($urandom); l = 8'($urandom);
    AWADDR = a; AWLEN = l; AWBURST = 2'b11; AWVALID = 1'b1; BREADY = 1'b1;
    tick(); AWVALID = 1'b0;
    total++;
    if ({cmd_write_o, cmd_burst_type_o, cmd_start_addr_o, cmd_transfer_len_o} !==
        {1'b1, 2'b01, a & 8'hFC, l}) begin
      bad++; $display("FAIL rsvd_cmd: got w=%b burst=%b addr=%h len=%h want 1 01 %h %h",
                      cmd_write_o, cmd_burst_type_o, cmd_start_addr_o, cmd_transfer_len_o,
                      a & 8'hFC, l);
    end
    ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0;
    total++;
    if ({BVALID, BRESP} !== 3'b110) begin
      bad++; $display("FAIL rsvd_bresp: got bvalid/bresp=%b want 110", {BVALID, BRESP});
    end
    tick();
    last_addr = a & 8'hFC; last_len = l; last_burst = 2'b01;
    model_last_w = 1'b1;
  endtask

  task automatic test_spurious();
    logic [7:0] a;
    ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0; #1;
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, BVALID, AWREADY, ARREADY} !== 6'b0 ||
        {cmd_start_addr_o, cmd_transfer_len_o, cmd_burst_type_o} !==
        {last_addr, last_len, last_burst}) begin
      bad++; $display("FAIL spur_idle: got v/r/w/b=%b addr=%h len=%h burst=%b want 0000 %h %h %b",
                      {ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, BVALID}, cmd_start_addr_o,
                      cmd_transfer_len_o, cmd_burst_type_o, last_addr, last_len, last_burst);
    end
    a = 8'($urandom);
    AWADDR = a; AWLEN = 8'd1; AWBURST = 2'($urandom_range(0, 2)); AWVALID = 1'b1; BREADY = 1'b0;
    tick(); AWVALID = 1'b0;
    ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0;
    tick();
    total++;
    if ({BVALID, BRESP, ctrl_cmd_valid_o, cmd_write_o} !== 5'b10000 ||
        cmd_start_addr_o !== (a & 8'hFC)) begin
      bad++; $display("FAIL spur_wresp: got bvalid/bresp/v/w=%b addr=%h want 10000 %h",
                      {BVALID, BRESP, ctrl_cmd_valid_o, cmd_write_o}, cmd_start_addr_o, a & 8'hFC);
    end
    BREADY = 1'b1; tick();
    model_last_w = 1'b1;
  endtask

  task automatic test_reset_midop();
    AWADDR = 8'($urandom); AWLEN = 8'($urandom); AWBURST = 2'b11; AWVALID = 1'b1;
    tick(); AWVALID = 1'b0;
    total++;
    if (cmd_write_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got w=%b want 1", cmd_write_o);
    end
    ARESET = 1'b1; tick(); #1;
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, BVALID, BRESP, AWREADY, ARREADY} !== 8'b0 ||
        {cmd_start_addr_o, cmd_transfer_len_o, cmd_burst_type_o} !== 18'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got ctl=%b addr=%h len=%h burst=%b want 0",
                      {ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, BVALID, BRESP, AWREADY, ARREADY},
                      cmd_start_addr_o, cmd_transfer_len_o, cmd_burst_type_o);
    end
    ARESET = 1'b0; model_last_w = 1'b0;
    ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0; tick();
    total++;
    if ({BVALID, ctrl_cmd_valid_o} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_nobresp: got bvalid/v=%b want 00", {BVALID, ctrl_cmd_valid_o});
    end
    ARADDR = 8'h47; ARLEN = 8'd2; ARBURST = 2'b00; ARVALID = 1'b1; #1;
    total++;
    if (ARREADY !== 1'b1) begin
      bad++; $display("FAIL rst_mid_arready: got %b want 1", ARREADY);
    end
    tick(); ARVALID = 1'b0;
    total++;
    if ({ctrl_cmd_valid_o, cmd_read_o, cmd_start_addr_o, cmd_transfer_len_o, cmd_burst_type_o} !==
        {2'b11, 8'h44, 8'd2, 2'b00}) begin
      bad++; $display("FAIL rst_mid_rd: got v/r=%b addr=%h len=%0d burst=%b want 11 44 2 00",
                      {ctrl_cmd_valid_o, cmd_read_o}, cmd_start_addr_o, cmd_transfer_len_o,
                      cmd_burst_type_o);
    end
    ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0;
    total++;
    if ({ctrl_cmd_valid_o, BVALID} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_rd_done: got v/bvalid=%b want 00", {ctrl_cmd_valid_o, BVALID});
    end
  endtask

  task automatic test_random();
    int ch;
    bit exp_w;
    logic [7:0] wa, wl, ra, rl;
    logic [1:0] wb, rb;
    logic [7:0] ea, el;
    logic [1:0] eb;
    for (int it = 0; it < 40; it++) begin
      ch = $urandom_range(0, 2);
      exp_w = (ch == 0) ? 1'b1 : (ch == 1) ? 1'b0 : ~model_last_w;
      wa = 8'($urandom); wl = 8'($urandom); wb = 2'($urandom);
      ra = 8'($urandom); rl = 8'($urandom); rb = 2'($urandom);
      AWADDR = wa; AWLEN = wl; AWBURST = wb; ARADDR = ra; ARLEN = rl; ARBURST = rb;
      AWVALID = (ch != 1); ARVALID = (ch != 0); BREADY = 1'b0; #1;
      total++;
      if ({AWREADY, ARREADY} !== {exp_w, ~exp_w}) begin
        bad++; $display("FAIL rnd_grant: iter %0d got aw/ar=%b want %b", it,
                        {AWREADY, ARREADY}, {exp_w, ~exp_w});
      end
      tick(); AWVALID = 1'b0; ARVALID = 1'b0;
      model_last_w = exp_w;
      ea = (exp_w ? wa : ra) & 8'hFC;
      el = exp_w ? wl : rl;
      eb = exp_burst(exp_w ? wb : rb);
      total++;
      if ({ctrl_cmd_valid_o, cmd_read_o, cmd_write_o, cmd_start_addr_o, cmd_transfer_len_o,
           cmd_burst_type_o} !== {1'b1, ~exp_w, exp_w, ea, el, eb}) begin
        bad++; $display("FAIL rnd_cmd: iter %0d got v/r/w=%b addr=%h len=%h burst=%b want %b %h %h %b",
                        it, {ctrl_cmd_valid_o, cmd_read_o, cmd_write_o}, cmd_start_addr_o,
                        cmd_transfer_len_o, cmd_burst_type_o, {1'b1, ~exp_w, exp_w}, ea, el, eb);
      end
      repeat ($urandom_range(0, 3)) tick();
      ctrl_cmd_ready_i = 1'b1; tick(); ctrl_cmd_ready_i = 1'b0;
      total++;
      if ({ctrl_cmd_valid_o, BVALID, BRESP} !== {1'b0, exp_w, exp_w ? exp_resp(wb) : 2'b00}) begin
        bad++; $display("FAIL rnd_done: iter %0d got v/bvalid/bresp=%b want %b", it,
                        {ctrl_cmd_valid_o, BVALID, BRESP},
                        {1'b0, exp_w, exp_w ? exp_resp(wb) : 2'b00});
      end
      if (exp_w) begin
        repeat ($urandom_range(0, 2)) tick();
        BREADY = 1'b1; tick();
        total++;
        if (BVALID !== 1'b0) begin
          bad++; $display("FAIL rnd_bdone: iter %0d got bvalid=%b want 0", it, BVALID);
        end
      end
    end
    BREADY = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; model_last_w = 1'b0;
    last_addr = 8'd0; last_len = 8'd0; last_burst = 2'd0;
    ARESET = 1'b1; AWADDR = 8'd0; AWLEN = 8'd0; AWBURST = 2'd0; AWVALID = 1'b0;
    ARADDR = 8'd0; ARLEN = 8'd0; ARBURST = 2'd0; ARVALID = 1'b0;
    BREADY = 1'b1; ctrl_cmd_ready_i = 1'b0;
    @(negedge ACLK);
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_reserved();
    test_spurious();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
